board_write_arbiter: RTL and testbench

- Owns the single write port shared by both board RAM copies (VGA display copy and win-condition copy).
- After reset, or on request, sweeps the default board from an initial-board ROM into all 768 blocks.
- After the sweep, arbitrates round-robin between two game-logic requesters: the Pac-Man update path and the ghost update path.
- Drives wr_en/wr_addr/wr_data directly onto both RAMs' wren/wraddress/data.

---
 rtl/board_write_arbiter_if.sv | 33 +++
 rtl/board_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_board_write_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_write_arbiter_if.sv
// Board RAM write-port bundle: init ROM fetch, two game-logic requesters and
// the shared write port driven onto both board RAM copies.
interface board_write_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
);
    logic              init_start;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              gnt0;
    logic              gnt1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              init_done;
    logic              oob_err;

    modport slave (
        input  init_start, rom_data, req0, req1, addr0, addr1, data0, data1,
        output rom_addr, gnt0, gnt1, wr_en, wr_addr, wr_data, init_done, oob_err
    );

    modport master (
        output init_start, rom_data, req0, req1, addr0, addr1, data0, data1,
        input  rom_addr, gnt0, gnt1, wr_en, wr_addr, wr_data, init_done, oob_err
    );
endinterface

// File: rtl/board_write_arbiter.sv
// Single write port for both board RAM copies: sweeps the initial-board ROM
// into every block, then round-robins Pac-Man / ghost write requests.
module board_write_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 4,
    parameter int NUM_BLOCKS = 768
) (
    input  logic                  clk,
    input  logic                  reset,
    board_write_arbiter_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_BLK = ADDR_W'(NUM_BLOCKS - 1);
    localparam logic [ADDR_W:0]   NB_EXT   = (ADDR_W+1)'(NUM_BLOCKS);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t r_state, w_state_nxt;

    logic [ADDR_W-1:0]            r_cnt;
    logic                         r_sweep_on;
    logic                         r_fetch_vld;
    logic [ADDR_W-1:0]            r_fetch_addr;
    logic [1:0]                   r_gnt;
    logic                         r_ptr;
    logic                         r_wr_en;
    logic [ADDR_W-1:0]            r_wr_addr;
    logic [DATA_W-1:0]            r_wr_data;
    logic                         r_oob;

    logic                         w_restart;
    logic                         w_arb_en;
    logic [1:0]                   w_req;
    logic [1:0][ADDR_W-1:0]       w_addr;
    logic [1:0][DATA_W-1:0]       w_data;
    logic [1:0]                   w_elig;
    logic                         w_sel;
    logic                         w_oob;

    assign w_req  = {bus.req1, bus.req0};
    assign w_addr = {bus.addr1, bus.addr0};
    assign w_data = {bus.data1, bus.data0};

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_INIT;
        else        r_state <= w_state_nxt;
    end

    // FSM: next state; leave INIT once the last block write is on the port
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT: if (r_wr_en && (r_wr_addr == LAST_BLK)) w_state_nxt = S_RUN;
            S_RUN:  if (bus.init_start)                     w_state_nxt = S_INIT;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // FSM: outputs / control strobes
    always_comb begin
        w_restart     = 1'b0;
        w_arb_en      = 1'b0;
        bus.init_done = 1'b0;
        case (r_state)
            S_RUN: begin
                bus.init_done = 1'b1;
                w_restart     = bus.init_start;
                w_arb_en      = !bus.init_start;
            end
            default: ;
        endcase
    end

    assign bus.rom_addr = r_cnt;

    // Sweep counter; r_fetch_* tracks the ROM read whose data lands next cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_sweep_on   <= 1'b1;
            r_fetch_vld  <= 1'b0;
            r_fetch_addr <= '0;
        end else if (w_restart) begin
            r_cnt        <= '0;
            r_sweep_on   <= 1'b1;
            r_fetch_vld  <= 1'b0;
        end else if (r_state == S_INIT && r_sweep_on) begin
            r_fetch_vld  <= 1'b1;
            r_fetch_addr <= r_cnt;
            if (r_cnt == LAST_BLK) begin
                r_cnt      <= '0;
                r_sweep_on <= 1'b0;
            end else begin
                r_cnt      <= r_cnt + 1'b1;
            end
        end else begin
            r_fetch_vld  <= 1'b0;
        end
    end

    // A requester whose grant is on the port this cycle is not eligible again
    assign w_elig = w_req & ~r_gnt;

    always_comb begin
        w_sel = r_ptr;
        if (w_elig == 2'b01)      w_sel = 1'b0;
        else if (w_elig == 2'b10) w_sel = 1'b1;
    end

    assign w_oob = ({1'b0, w_addr[w_sel]} >= NB_EXT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt     <= '0;
            r_ptr     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_oob     <= 1'b0;
        end else begin
            r_gnt   <= '0;
            r_wr_en <= 1'b0;
            r_oob   <= 1'b0;
            if (r_state == S_INIT) begin
                if (r_fetch_vld) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_fetch_addr;
                    r_wr_data <= bus.rom_data;
                end
            end else if (w_arb_en && (w_elig != 2'b00)) begin
                r_gnt[w_sel] <= 1'b1;
                r_wr_addr    <= w_addr[w_sel];
                r_wr_data    <= w_data[w_sel];
                r_wr_en      <= !w_oob;
                r_oob        <= w_oob;
                r_ptr        <= !w_sel;
            end
        end
    end

    assign bus.gnt0    = r_gnt[0];
    assign bus.gnt1    = r_gnt[1];
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.oob_err = r_oob;
endmodule

// File: tb/tb_board_write_arbiter.sv
// Self-checking bench for board_write_arbiter: ROM sweep, arbitration,
// out-of-range writes, reload and mid-sweep reset.
module tb_board_write_arbiter;
    localparam int AW = 10;
    localparam int DW = 4;
    localparam int NB = 768;

    typedef struct {
        logic          g0;
        logic          g1;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          en;
        logic          oob;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_ptr   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    board_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    board_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_BLOCKS(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Initial-board ROM: synchronous, contents = address mod 16
    always_ff @(posedge clk) bus.rom_data <= bus.rom_addr[3:0];

    function automatic exp_t mk(logic g0, logic g1, int a, int d, logic en, logic oob);
        exp_t e;
        e.g0 = g0; e.g1 = g1; e.a = AW'(a); e.d = DW'(d); e.en = en; e.oob = oob;
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick(); tick();
        n_tests++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.gnt0, bus.gnt1, bus.init_done,
             bus.oob_err, bus.rom_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got en=%b addr=%0d data=%0d g=%b%b done=%b oob=%b rom=%0d exp all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.gnt0, bus.gnt1, bus.init_done,
                     bus.oob_err, bus.rom_addr);
        end
    endtask

    task automatic test_sweep;
        exp_t e;
        logic exp_en, exp_done;
        q.delete();
        for (int k = 0; k < NB; k++) q.push_back(mk(1'b0, 1'b0, k, k % 16, 1'b1, 1'b0));
        reset = 1'b1;
        for (int cyc = 1; cyc <= 771; cyc++) begin
            tick();
            exp_en   = (cyc >= 2) && (cyc <= 769);
            exp_done = (cyc >= 770);
            n_tests++;
            if ({bus.wr_en, bus.init_done, bus.gnt0, bus.gnt1, bus.oob_err} !==
                {exp_en, exp_done, 3'b000}) begin
                n_fail++;
                $display("FAIL sweep_ctrl cyc=%0d got en/done/g0/g1/oob=%b exp=%b", cyc,
                         {bus.wr_en, bus.init_done, bus.gnt0, bus.gnt1, bus.oob_err},
                         {exp_en, exp_done, 3'b000});
            end
            if (bus.wr_en) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sweep_extra cyc=%0d got addr=%0d exp no write", cyc, bus.wr_addr);
                end else begin
                    e = q.pop_front();
                    if ({bus.wr_addr, bus.wr_data} !== {e.a, e.d}) begin
                        n_fail++;
                        $display("FAIL sweep_write cyc=%0d got addr=%0d data=%0d exp addr=%0d data=%0d",
                                 cyc, bus.wr_addr, bus.wr_data, e.a, e.d);
                    end
                end
            end
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL sweep_missing got %0d writes left exp 0", q.size());
        end
    endtask

    task automatic test_single;
        exp_t e;
        bus.req0 = 1'b1; bus.addr0 = 10'd37; bus.data0 = 4'd5;
        q.push_back(mk(1'b1, 1'b0, 37, 5, 1'b1, 1'b0));
        m_ptr = 1;
        tick();
        bus.req0 = 1'b0;
        e = q.pop_front();
        n_tests++;
        if ({bus.gnt0, bus.gnt1, bus.wr_addr, bus.wr_data, bus.wr_en, bus.oob_err} !==
            {e.g0, e.g1, e.a, e.d, e.en, e.oob}) begin
            n_fail++;
            $display("FAIL single_grant got g=%b%b addr=%0d data=%0d en=%b oob=%b exp g=%b%b addr=%0d data=%0d en=%b oob=%b",
                     bus.gnt0, bus.gnt1, bus.wr_addr, bus.wr_data, bus.wr_en, bus.oob_err,
                     e.g0, e.g1, e.a, e.d, e.en, e.oob);
        end
        tick();
        n_tests++;
        if ({bus.gnt0, bus.gnt1, bus.wr_en, bus.wr_addr, bus.wr_data} !== {3'b000, 10'd37, 4'd5}) begin
            n_fail++;
            $display("FAIL single_idle got g=%b%b en=%b addr=%0d data=%0d exp g=00 en=0 addr=37 data=5",
                     bus.gnt0, bus.gnt1, bus.wr_en, bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic test_oob;
        exp_t e;
        bus.req1 = 1'b1; bus.addr1 = 10'd800; bus.data1 = 4'd3;
        q.push_back(mk(1'b0, 1'b1, 800, 3, 1'b0, 1'b1));
        m_ptr = 0;
        tick();
        bus.req1 = 1'b0;
        e = q.pop_front();
        n_tests++;
        if ({bus.gnt0, bus.gnt1, bus.wr_addr, bus.wr_data, bus.wr_en, bus.oob_err} !==
            {e.g0, e.g1, e.a, e.d, e.en, e.oob}) begin
            n_fail++;
            $display("FAIL oob_grant got g=%b%b addr=%0d data=%0d en=%b oob=%b exp g=%b%b addr=%0d data=%0d en=%b oob=%b",
                     bus.gnt0, bus.gnt1, bus.wr_addr, bus.wr_data, bus.wr_en, bus.oob_err,
                     e.g0, e.g1, e.a, e.d, e.en, e.oob);
        end
        tick();
        n_tests++;
        if ({bus.oob_err, bus.gnt1, bus.wr_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL oob_pulse got oob/g1/en=%b exp 000", {bus.oob_err, bus.gnt1, bus.wr_en});
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   cur;
        logic pg0, pg1;
        bus.req0 = 1'b1; bus.addr0 = 10'd10; bus.data0 = 4'd1;
        bus.req1 = 1'b1; bus.addr1 = 10'd20; bus.data1 = 4'd2;
        cur = m_ptr;
        for (int i = 0; i < 8; i++) begin
            if (cur == 0) q.push_back(mk(1'b1, 1'b0, 10, 1, 1'b1, 1'b0));
            else          q.push_back(mk(1'b0, 1'b1, 20, 2, 1'b1, 1'b0));
            cur = 1 - cur;
        end
        m_ptr = cur;
        pg0 = 1'b0; pg1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = q.pop_front();
            n_tests++;
            if ({bus.gnt0, bus.gnt1, bus.wr_addr, bus.wr_data, bus.wr_en, bus.oob_err} !==
                {e.g0, e.g1, e.a, e.d, e.en, e.oob}) begin
                n_fail++;
                $display("FAIL b2b_grant i=%0d got g=%b%b addr=%0d data=%0d en=%b exp g=%b%b addr=%0d data=%0d en=%b",
                         i, bus.gnt0, bus.gnt1, bus.wr_addr, bus.wr_data, bus.wr_en,
                         e.g0, e.g1, e.a, e.d, e.en);
            end
            n_tests++;
            if ((bus.gnt0 && pg0) || (bus.gnt1 && pg1)) begin
                n_fail++;
                $display("FAIL b2b_repeat i=%0d got g=%b%b after g=%b%b exp alternation",
                         i, bus.gnt0, bus.gnt1, pg0, pg1);
            end
            pg0 = bus.gnt0; pg1 = bus.gnt1;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        n_tests++;
        if ({bus.gnt0, bus.gnt1, bus.wr_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_release got g0/g1/en=%b exp 000", {bus.gnt0, bus.gnt1, bus.wr_en});
        end
    endtask

    task automatic test_init_start;
        exp_t e;
        int   cyc;
        int   nwr;
        bus.init_start = 1'b1;
        bus.req0 = 1'b1; bus.addr0 = 10'd55; bus.data0 = 4'd7;
        q.push_back(mk(1'b1, 1'b0, 55, 7, 1'b1, 1'b0));
        tick();
        bus.init_start = 1'b0;
        cyc = 1; nwr = 0;
        while (!bus.init_done && cyc < 1000) begin
            n_tests++;
            if (bus.gnt0 || bus.gnt1) begin
                n_fail++;
                $display("FAIL reload_grant cyc=%0d got g=%b%b exp 00", cyc, bus.gnt0, bus.gnt1);
            end
            if (bus.wr_en) begin
                nwr++;
                n_tests++;
                if (bus.wr_data !== bus.wr_addr[3:0]) begin
                    n_fail++;
                    $display("FAIL reload_data addr=%0d got %0d exp %0d",
                             bus.wr_addr, bus.wr_data, bus.wr_addr[3:0]);
                end
            end
            tick();
            cyc++;
        end
        n_tests++;
        if (cyc != 771) begin
            n_fail++;
            $display("FAIL reload_done_cycle got %0d exp 771", cyc);
        end
        n_tests++;
        if (nwr != NB) begin
            n_fail++;
            $display("FAIL reload_write_count got %0d exp %0d", nwr, NB);
        end
        tick();
        bus.req0 = 1'b0;
        m_ptr = 1;
        e = q.pop_front();
        n_tests++;
        if ({bus.gnt0, bus.gnt1, bus.wr_addr, bus.wr_data, bus.wr_en, bus.oob_err} !==
            {e.g0, e.g1, e.a, e.d, e.en, e.oob}) begin
            n_fail++;
            $display("FAIL reload_first_grant got g=%b%b addr=%0d data=%0d en=%b exp g=%b%b addr=%0d data=%0d en=%b",
                     bus.gnt0, bus.gnt1, bus.wr_addr, bus.wr_data, bus.wr_en,
                     e.g0, e.g1, e.a, e.d, e.en);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int found;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        found = 0;
        for (int cyc = 1; cyc < 1000 && found == 0; cyc++) begin
            tick();
            if (bus.wr_en && bus.wr_addr == 10'd300) found = 1;
        end
        n_tests++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL midrst_reach got no write to 300 exp one within 1000 cycles");
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.gnt0, bus.gnt1, bus.init_done,
                 bus.oob_err, bus.rom_addr} !== '0) begin
                n_fail++;
                $display("FAIL midrst_zero i=%0d got en=%b addr=%0d data=%0d rom=%0d exp all 0",
                         i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.rom_addr);
            end
            if (i < 3) tick();
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_cyc1 got en=%b exp 0", bus.wr_en);
        end
        tick();
        n_tests++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 10'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL midrst_restart got en=%b addr=%0d data=%0d exp en=1 addr=0 data=0",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        found = 0;
        for (int cyc = 0; cyc < 1000 && found == 0; cyc++) begin
            tick();
            if (bus.init_done) found = 1;
        end
        n_tests++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL midrst_done got init_done=0 exp 1 within 1000 cycles");
        end
    endtask

    initial begin
        bus.init_start = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.data0 = '0; bus.data1 = '0;
        test_reset();
        test_sweep();
        test_single();
        test_oob();
        test_back_to_back();
        test_init_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
